ex_stage: RTL



---
 rtl/ex_stage_if.sv | 30 +++
 rtl/ex_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_if.sv
// Bundle of the execute stage's pipeline-facing signals: stall vector, decode bundle,
// forwarding/MEM bundles, data-SRAM request and the EX busy flag.
interface ex_stage_if #(
    parameter int ID_TO_EX_WD  = 167,
    parameter int EX_TO_MEM_WD = 82,
    parameter int StallBus     = 6
);
    logic [StallBus-1:0]     stall;
    logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [38:0]             ex_to_rf_bus;
    logic                    data_sram_en;
    logic [3:0]              data_sram_wen;
    logic [31:0]             data_sram_addr;
    logic [31:0]             data_sram_wdata;
    logic                    stallreq_for_ex;

    // master: the decode/control side feeding EX; slave: the execute stage itself
    modport master (
        output stall, id_to_ex_bus,
        input  ex_to_mem_bus, ex_to_rf_bus, data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata, stallreq_for_ex
    );

    modport slave (
        input  stall, id_to_ex_bus,
        output ex_to_mem_bus, ex_to_rf_bus, data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata, stallreq_for_ex
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: latches the decode bundle, runs the ALU, owns HI/LO with a
// single-cycle multiplier and a 32-cycle restoring divider, and issues data-SRAM requests.
module ex_stage #(
    parameter int ID_TO_EX_WD  = 167,
    parameter int EX_TO_MEM_WD = 82,
    parameter int StallBus     = 6
) (
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   bus
);
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;

    logic [ID_TO_EX_WD-1:0] ex_q;

    // load and bubble both retire whatever divide was sitting in EX
    logic ex_advance;
    assign ex_advance = (bus.stall[2] == NoStop) || (bus.stall[3] == NoStop);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else if (bus.stall[2] == Stop && bus.stall[3] == NoStop) begin
            ex_q <= '0;
        end else if (bus.stall[2] == NoStop) begin
            ex_q <= bus.id_to_ex_bus;
        end
    end

    logic [7:0]  hilo_op;
    logic [31:0] id_pc, inst, rdata1, rdata2;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2, ram_wen;
    logic        ram_en, rf_we, sel_rf_res;
    logic [4:0]  rf_waddr;

    assign {hilo_op, id_pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen,
            rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = ex_q;

    logic [31:0] src1, src2, alu_res, ex_result;
    assign src1 = ({32{sel_src1[0]}} & rdata1)
                | ({32{sel_src1[1]}} & id_pc)
                | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
    assign src2 = ({32{sel_src2[0]}} & rdata2)
                | ({32{sel_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
                | ({32{sel_src2[2]}} & 32'd8)
                | ({32{sel_src2[3]}} & {16'b0, inst[15:0]});

    always_comb begin
        alu_res = '0;
        if (alu_op[11]) alu_res = alu_res | (src1 + src2);
        if (alu_op[10]) alu_res = alu_res | (src1 - src2);
        if (alu_op[9])  alu_res = alu_res | {31'b0, $signed(src1) < $signed(src2)};
        if (alu_op[8])  alu_res = alu_res | {31'b0, src1 < src2};
        if (alu_op[7])  alu_res = alu_res | (src1 & src2);
        if (alu_op[6])  alu_res = alu_res | ~(src1 | src2);
        if (alu_op[5])  alu_res = alu_res | (src1 | src2);
        if (alu_op[4])  alu_res = alu_res | (src1 ^ src2);
        if (alu_op[3])  alu_res = alu_res | (src2 << src1[4:0]);
        if (alu_op[2])  alu_res = alu_res | (src2 >> src1[4:0]);
        if (alu_op[1])  alu_res = alu_res | 32'($signed(src2) >>> src1[4:0]);
        if (alu_op[0])  alu_res = alu_res | {src2[15:0], 16'b0};
    end

    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    assign ex_result = hilo_op[7] ? hi_q : (hilo_op[6] ? lo_q : alu_res);

    // the decoded wen field is the unshifted lane mask (sb/sh/sw); loads carry zero
    logic [3:0]  sram_wen;
    logic [31:0] sram_wdata;
    always_comb begin
        sram_wen   = 4'b0000;
        sram_wdata = rdata2;
        case (ram_wen)
            4'b0001: begin
                sram_wen   = 4'b0001 << alu_res[1:0];
                sram_wdata = {4{rdata2[7:0]}};
            end
            4'b0011: begin
                sram_wen   = 4'b0011 << alu_res[1:0];
                sram_wdata = {2{rdata2[15:0]}};
            end
            4'b1111: sram_wen = 4'b1111;
            default: sram_wen = 4'b0000;
        endcase
    end

    assign bus.data_sram_en    = ram_en & (bus.stall[3] == NoStop);
    assign bus.data_sram_wen   = sram_wen;
    assign bus.data_sram_addr  = alu_res;
    assign bus.data_sram_wdata = sram_wdata;
    assign bus.ex_to_rf_bus    = {sel_rf_res, rf_we, rf_waddr, ex_result};
    assign bus.ex_to_mem_bus   = {id_pc, inst[31:26], ram_en, ram_wen, sel_rf_res,
                                  rf_we, rf_waddr, ex_result};

    logic [63:0] prod_s, prod_u;
    assign prod_s = $signed({{32{rdata1[31]}}, rdata1}) * $signed({{32{rdata2[31]}}, rdata2});
    assign prod_u = {32'b0, rdata1} * {32'b0, rdata2};

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, div_done_q, div_done_d;
    logic        is_div, is_sdiv;
    logic [32:0] shifted, trial;

    assign is_div  = hilo_op[1] | hilo_op[0];
    assign is_sdiv = hilo_op[1];
    assign shifted = {rem_q, quo_q[31]};
    assign trial   = shifted - {1'b0, dvs_q};

    assign bus.stallreq_for_ex = (is_div & ~div_done_q & (state_q != DONE)) | (state_q == RUN);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        div_done_d = div_done_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        if (hilo_op[3]) {hi_d, lo_d} = prod_s;
        if (hilo_op[2]) {hi_d, lo_d} = prod_u;
        if (hilo_op[5]) hi_d = rdata1;
        if (hilo_op[4]) lo_d = rdata1;

        case (state_q)
            IDLE: begin
                if (is_div && !div_done_q) begin
                    state_d   = RUN;
                    cnt_d     = 5'd0;
                    rem_d     = '0;
                    quo_d     = (is_sdiv && rdata1[31]) ? 32'd0 - rdata1 : rdata1;
                    dvs_d     = (is_sdiv && rdata2[31]) ? 32'd0 - rdata2 : rdata2;
                    neg_quo_d = is_sdiv & (rdata1[31] ^ rdata2[31]);
                    neg_rem_d = is_sdiv & rdata1[31];
                end
            end
            RUN: begin
                // quo_q shifts the dividend out of its MSB while quotient bits enter at the LSB
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = DONE;
            end
            DONE: begin
                lo_d       = neg_quo_q ? 32'd0 - quo_q : quo_q;
                hi_d       = neg_rem_q ? 32'd0 - rem_q : rem_q;
                div_done_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (ex_advance) div_done_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_done_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            div_done_q <= div_done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end
endmodule
